// File: rtl/vrf_pkg.sv
// vrf_pkg: shared types and width helpers for the vector register file sequencer
package vrf_pkg;
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
  localparam int vrf_els_c = 32;
  localparam int vrf_reg_w_c = safe_clog2(vrf_els_c);
  typedef logic [vrf_reg_w_c-1:0] vrf_reg_t;
  typedef struct packed {
    vrf_reg_t rs0;
    vrf_reg_t rs1;
    vrf_reg_t rs2;
    vrf_reg_t rd;
  } vrf_cmd_s;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} vrf_seq_state_e;
endpackage

// File: rtl/vrf_seq_delay.sv
// vrf_seq_delay: lat_p-stage valid+payload shift register with synchronous clear
module vrf_seq_delay #(
  parameter int lat_p = 3,
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic               pend_o
);
  logic [lat_p-1:0] v_q;
  logic [lat_p-1:0][width_p-1:0] d_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q[0] <= v_i;
      d_q[0] <= data_i;
      for (int i = 1; i < lat_p; i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
      end
    end
  end
  // pend_o: something will still be in flight after the next shift
  always_comb begin
    pend_o = 1'b0;
    for (int i = 0; i < lat_p - 1; i++) pend_o = pend_o | v_q[i];
  end
  assign v_o = v_q[lat_p-1];
  assign data_o = d_q[lat_p-1];
endmodule

// File: rtl/vrf_seq.sv
// vrf_seq: walks one vector op in lane groups, issuing VRF read then delayed write addresses
module vrf_seq import vrf_pkg::*; #(
  parameter int els_p = 32,
  parameter int vlen_p = 8,
  parameter int lanes_p = 4,
  parameter int lat_p = 3,
  localparam int v_addr_width_lp = safe_clog2(els_p),
  localparam int local_addr_width_lp = safe_clog2(vlen_p),
  localparam int groups_lp = vlen_p / lanes_p
) (
  input  logic                                          clk_i,
  input  logic                                          reset_i,
  input  logic                                          v_i,
  output logic                                          ready_o,
  input  logic [v_addr_width_lp-1:0]                    rs0_i,
  input  logic [v_addr_width_lp-1:0]                    rs1_i,
  input  logic [v_addr_width_lp-1:0]                    rs2_i,
  input  logic [v_addr_width_lp-1:0]                    rd_i,
  output logic [lanes_p-1:0][v_addr_width_lp-1:0]       r_reg0_addr_o,
  output logic [lanes_p-1:0][v_addr_width_lp-1:0]       r_reg1_addr_o,
  output logic [lanes_p-1:0][v_addr_width_lp-1:0]       r_reg2_addr_o,
  output logic [lanes_p-1:0][local_addr_width_lp-1:0]   r_addr_o,
  output logic                                          r_v_o,
  output logic [v_addr_width_lp-1:0]                    w_reg_addr_o,
  output logic [lanes_p-1:0][local_addr_width_lp-1:0]   w_addr_o,
  output logic [lanes_p-1:0]                            w_en_o,
  output logic                                          done_o
);
  localparam int gw_lp = safe_clog2(groups_lp);
  typedef logic [lanes_p-1:0][local_addr_width_lp-1:0] lane_addr_t;
  function automatic lane_addr_t lane_addr(input int g);
    for (int l = 0; l < lanes_p; l++) lane_addr[l] = local_addr_width_lp'(g * lanes_p + l);
  endfunction
  vrf_seq_state_e state_q;
  vrf_cmd_s cmd_q;
  logic [gw_lp-1:0] g_q, w_g;
  lane_addr_t r_addr_q;
  logic done_q, w_v, pend;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      g_q <= '0;
      cmd_q <= '0;
      r_addr_q <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (v_i) begin
          state_q <= ISSUE;
          g_q <= '0;
          cmd_q <= {vrf_reg_t'(rs0_i), vrf_reg_t'(rs1_i), vrf_reg_t'(rs2_i), vrf_reg_t'(rd_i)};
          r_addr_q <= lane_addr(0);
        end
        ISSUE: if (g_q == gw_lp'(groups_lp - 1)) state_q <= DRAIN;
        else begin
          g_q <= g_q + 1'b1;
          r_addr_q <= lane_addr(int'(g_q) + 1);
        end
        DRAIN: if (!pend) begin
          state_q <= IDLE;
          done_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  vrf_seq_delay #(.lat_p(lat_p), .width_p(gw_lp)) dly (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .v_i(r_v_o),
    .data_i(g_q),
    .v_o(w_v),
    .data_o(w_g),
    .pend_o(pend)
  );
  assign ready_o = (state_q == IDLE) & ~reset_i;
  assign r_v_o = (state_q == ISSUE);
  assign done_o = done_q;
  assign r_addr_o = r_addr_q;
  assign r_reg0_addr_o = {lanes_p{v_addr_width_lp'(cmd_q.rs0)}};
  assign r_reg1_addr_o = {lanes_p{v_addr_width_lp'(cmd_q.rs1)}};
  assign r_reg2_addr_o = {lanes_p{v_addr_width_lp'(cmd_q.rs2)}};
  assign w_reg_addr_o = v_addr_width_lp'(cmd_q.rd);
  assign w_en_o = {lanes_p{w_v}};
  assign w_addr_o = w_v ? lane_addr(int'(w_g)) : '0;
endmodule
